irq_priority_ctrl: RTL and testbench

Eight-input interrupt controller built around an 8-to-3 highest-index-wins priority encode. It latches rising edges on eight interrupt lines into a pending register and applies a software-writable mask. It presents the highest-priority unmasked pending source to a single consumer through a request/acknowledge handshake, then holds that source in service until end-of-interrupt (EOI). It sits between peripheral interrupt lines and the core's interrupt entry logic.

---
 rtl/irq_priority_ctrl.sv | 166 ++++++++++++++++
 tb/tb_irq_priority_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_priority_ctrl.sv
//-----------------------------------------------------------------------------
// irq_priority_ctrl
//
// Eight-input interrupt controller. Rising edges on irq_in are latched into a
// pending register. A software-writable mask gates which pending sources may
// request. The highest-index unmasked pending source is offered to a single
// consumer through a request/acknowledge handshake. Once acknowledged, that
// source is held in service until end-of-interrupt (EOI). Service is never
// nested.
//
// Parameters
//   MASK_RST   reset value of the mask register (bit = 1 masks the source)
//
// Ports
//   clk        in   1  system clock, rising-edge active
//   rst        in   1  asynchronous active-high reset
//   irq_in     in   8  interrupt lines, bit 7 highest priority
//   mask_wr    in   1  mask write strobe
//   mask_data  in   8  mask value loaded when mask_wr = 1
//   irq_ack    in   1  consumer accepts the presented vector (honoured in REQ)
//   eoi        in   1  consumer finished servicing (honoured in SERVICE)
//   irq_req    out  1  an unmasked source is being presented
//   irq_id     out  3  presented source index, valid while irq_req = 1
//   active_id  out  3  in-service source index, valid while busy = 1
//   busy       out  1  a source is in service
//   pending    out  8  pending register
//   mask       out  8  current mask register
//
// All outputs are driven straight from registers.
//-----------------------------------------------------------------------------
module irq_priority_ctrl #(
  parameter logic [7:0] MASK_RST = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irq_in,
  input  logic       mask_wr,
  input  logic [7:0] mask_data,
  input  logic       irq_ack,
  input  logic       eoi,
  output logic       irq_req,
  output logic [2:0] irq_id,
  output logic [2:0] active_id,
  output logic       busy,
  output logic [7:0] pending,
  output logic [7:0] mask
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  logic [1:0] r_state;
  logic [7:0] r_irq_q;
  logic [7:0] r_pending;
  logic [7:0] r_mask;
  logic       r_irq_req;
  logic [2:0] r_irq_id;
  logic [2:0] r_active_id;
  logic       r_busy;

  logic [7:0] w_edge;
  logic [7:0] w_elig;
  logic       w_any;
  logic [2:0] w_sel;
  logic       w_take;
  logic [7:0] w_clr;

  // One event per low-to-high transition; a held level does not re-trigger.
  assign w_edge = irq_in & ~r_irq_q;

  // Highest-index-wins encode: ascending scan, so the last hit is the winner.
  always_comb begin
    w_elig = r_pending & ~r_mask;
    w_any  = |w_elig;
    w_sel  = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (w_elig[i]) begin
        w_sel = 3'(i);
      end
    end
  end

  // The acknowledge consumes the vector registered before this edge, so a
  // simultaneous mask write cannot redirect which pending bit is cleared.
  always_comb begin
    w_take = (r_state == ST_REQ) && irq_ack;
    w_clr  = '0;
    if (w_take) begin
      w_clr = 8'b0000_0001 << r_irq_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_irq_q     <= '0;
      r_pending   <= '0;
      r_mask      <= MASK_RST;
      r_irq_req   <= 1'b0;
      r_irq_id    <= '0;
      r_active_id <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_irq_q <= irq_in;

      // Clear first, then OR in new edges: an edge arriving in the same
      // cycle as the acknowledge keeps the bit pending.
      r_pending <= (r_pending & ~w_clr) | w_edge;

      if (mask_wr) begin
        r_mask <= mask_data;
      end

      case (r_state)
        ST_IDLE: begin
          r_irq_req <= 1'b0;
          r_busy    <= 1'b0;
          if (w_any) begin
            r_state   <= ST_REQ;
            r_irq_req <= 1'b1;
            r_irq_id  <= w_sel;
          end
        end

        ST_REQ: begin
          if (irq_ack) begin
            r_state     <= ST_SERVICE;
            r_active_id <= r_irq_id;
            r_irq_req   <= 1'b0;
            r_busy      <= 1'b1;
          end else if (!w_any) begin
            // Every candidate was masked away before acceptance.
            r_state   <= ST_IDLE;
            r_irq_req <= 1'b0;
          end else begin
            // Re-evaluate so a higher source arriving before ack replaces
            // the presented vector.
            r_irq_id <= w_sel;
          end
        end

        ST_SERVICE: begin
          if (eoi) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          r_irq_req <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign irq_req   = r_irq_req;
  assign irq_id    = r_irq_id;
  assign active_id = r_active_id;
  assign busy      = r_busy;
  assign pending   = r_pending;
  assign mask      = r_mask;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
//-----------------------------------------------------------------------------
// tb_irq_priority_ctrl
//
// Directed bench for irq_priority_ctrl. A cycle-by-cycle vector table walks
// through single-source service, priority, preemption before ack, masking,
// ack/mask and ack/edge collisions and ignored handshake inputs. Hand-written
// sequences cover a held-high line and reset asserted in the middle of a
// request. Inputs change 1 ns after the rising edge; outputs are checked at
// that same point, i.e. reflecting the edge just taken.
//-----------------------------------------------------------------------------
module tb_irq_priority_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] irq_in;
  logic       mask_wr;
  logic [7:0] mask_data;
  logic       irq_ack;
  logic       eoi;
  logic       irq_req;
  logic [2:0] irq_id;
  logic [2:0] active_id;
  logic       busy;
  logic [7:0] pending;
  logic [7:0] mask;

  int n_checks;
  int n_errors;

  irq_priority_ctrl #(
    .MASK_RST(8'h00)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .irq_in   (irq_in),
    .mask_wr  (mask_wr),
    .mask_data(mask_data),
    .irq_ack  (irq_ack),
    .eoi      (eoi),
    .irq_req  (irq_req),
    .irq_id   (irq_id),
    .active_id(active_id),
    .busy     (busy),
    .pending  (pending),
    .mask     (mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] irq;
    logic       mwr;
    logic [7:0] mdata;
    logic       ack;
    logic       eoi;
    logic       req;
    logic [2:0] id;
    logic       busy;
    logic [2:0] act;
    logic [7:0] pend;
    logic [7:0] msk;
  } vec_t;

  vec_t vt[39];

  function automatic vec_t mk(input logic [7:0] irq, input logic mwr,
                              input logic [7:0] mdata, input logic ack,
                              input logic e, input logic req,
                              input logic [2:0] id, input logic bsy,
                              input logic [2:0] act, input logic [7:0] pend,
                              input logic [7:0] msk);
    vec_t v;
    v.irq = irq; v.mwr = mwr; v.mdata = mdata; v.ack = ack; v.eoi = e;
    v.req = req; v.id = id; v.busy = bsy; v.act = act; v.pend = pend;
    v.msk = msk;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int nsvc;
  logic last_ack;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    irq_in    = '0;
    mask_wr   = 1'b0;
    mask_data = '0;
    irq_ack   = 1'b0;
    eoi       = 1'b0;

    //            irq   mw mdata ack eoi  req id bsy act pend   mask
    vt[0]  = mk(8'h08, 0, 8'h00, 0, 0,   0, 0, 0, 0, 8'h08, 8'h00);
    vt[1]  = mk(8'h00, 0, 8'h00, 0, 0,   1, 3, 0, 0, 8'h08, 8'h00);
    vt[2]  = mk(8'h00, 0, 8'h00, 1, 0,   0, 0, 1, 3, 8'h00, 8'h00);
    vt[3]  = mk(8'h00, 0, 8'h00, 1, 0,   0, 0, 1, 3, 8'h00, 8'h00);
    vt[4]  = mk(8'h00, 0, 8'h00, 0, 1,   0, 0, 0, 0, 8'h00, 8'h00);
    vt[5]  = mk(8'h00, 0, 8'h00, 1, 0,   0, 0, 0, 0, 8'h00, 8'h00);
    vt[6]  = mk(8'h22, 0, 8'h00, 0, 0,   0, 0, 0, 0, 8'h22, 8'h00);
    vt[7]  = mk(8'h00, 0, 8'h00, 0, 0,   1, 5, 0, 0, 8'h22, 8'h00);
    vt[8]  = mk(8'h80, 0, 8'h00, 0, 0,   1, 5, 0, 0, 8'hA2, 8'h00);
    vt[9]  = mk(8'h00, 0, 8'h00, 0, 0,   1, 7, 0, 0, 8'hA2, 8'h00);
    vt[10] = mk(8'h00, 0, 8'h00, 0, 1,   1, 7, 0, 0, 8'hA2, 8'h00);
    vt[11] = mk(8'h00, 0, 8'h00, 1, 0,   0, 0, 1, 7, 8'h22, 8'h00);
    vt[12] = mk(8'h00, 0, 8'h00, 0, 1,   0, 0, 0, 0, 8'h22, 8'h00);
    vt[13] = mk(8'h00, 0, 8'h00, 0, 0,   1, 5, 0, 0, 8'h22, 8'h00);
    vt[14] = mk(8'h00, 0, 8'h00, 1, 0,   0, 0, 1, 5, 8'h02, 8'h00);
    vt[15] = mk(8'h00, 0, 8'h00, 0, 1,   0, 0, 0, 0, 8'h02, 8'h00);
    vt[16] = mk(8'h00, 0, 8'h00, 0, 0,   1, 1, 0, 0, 8'h02, 8'h00);
    vt[17] = mk(8'h00, 0, 8'h00, 1, 0,   0, 0, 1, 1, 8'h00, 8'h00);
    vt[18] = mk(8'h00, 0, 8'h00, 0, 1,   0, 0, 0, 0, 8'h00, 8'h00);
    vt[19] = mk(8'h00, 1, 8'h80, 0, 0,   0, 0, 0, 0, 8'h00, 8'h80);
    vt[20] = mk(8'h80, 0, 8'h00, 0, 0,   0, 0, 0, 0, 8'h80, 8'h80);
    vt[21] = mk(8'h00, 0, 8'h00, 0, 0,   0, 0, 0, 0, 8'h80, 8'h80);
    vt[22] = mk(8'h00, 0, 8'h00, 0, 0,   0, 0, 0, 0, 8'h80, 8'h80);
    vt[23] = mk(8'h00, 1, 8'h00, 0, 0,   0, 0, 0, 0, 8'h80, 8'h00);
    vt[24] = mk(8'h00, 0, 8'h00, 0, 0,   1, 7, 0, 0, 8'h80, 8'h00);
    vt[25] = mk(8'h00, 1, 8'h80, 0, 0,   1, 7, 0, 0, 8'h80, 8'h80);
    vt[26] = mk(8'h00, 0, 8'h00, 0, 0,   0, 0, 0, 0, 8'h80, 8'h80);
    vt[27] = mk(8'h00, 1, 8'h00, 0, 0,   0, 0, 0, 0, 8'h80, 8'h00);
    vt[28] = mk(8'h00, 0, 8'h00, 0, 0,   1, 7, 0, 0, 8'h80, 8'h00);
    vt[29] = mk(8'h00, 1, 8'hFF, 1, 0,   0, 0, 1, 7, 8'h00, 8'hFF);
    vt[30] = mk(8'h00, 1, 8'h00, 0, 1,   0, 0, 0, 0, 8'h00, 8'h00);
    vt[31] = mk(8'h04, 0, 8'h00, 0, 0,   0, 0, 0, 0, 8'h04, 8'h00);
    vt[32] = mk(8'h00, 0, 8'h00, 0, 0,   1, 2, 0, 0, 8'h04, 8'h00);
    vt[33] = mk(8'h04, 0, 8'h00, 1, 0,   0, 0, 1, 2, 8'h04, 8'h00);
    vt[34] = mk(8'h00, 0, 8'h00, 0, 0,   0, 0, 1, 2, 8'h04, 8'h00);
    vt[35] = mk(8'h00, 0, 8'h00, 0, 1,   0, 0, 0, 0, 8'h04, 8'h00);
    vt[36] = mk(8'h00, 0, 8'h00, 0, 0,   1, 2, 0, 0, 8'h04, 8'h00);
    vt[37] = mk(8'h00, 0, 8'h00, 1, 0,   0, 0, 1, 2, 8'h00, 8'h00);
    vt[38] = mk(8'h00, 0, 8'h00, 0, 1,   0, 0, 0, 0, 8'h00, 8'h00);

    // Reset state while rst is held.
    #2;
    chk("rst_req",     {7'd0, irq_req}, 8'h00);
    chk("rst_busy",    {7'd0, busy},    8'h00);
    chk("rst_pending", pending,         8'h00);
    chk("rst_mask",    mask,            8'h00);
    chk("rst_id",      {5'd0, irq_id},  8'h00);
    chk("rst_active",  {5'd0, active_id}, 8'h00);
    tick();
    tick();
    rst = 1'b0;

    // Table-driven sequence.
    for (int i = 0; i < 39; i++) begin
      irq_in    = vt[i].irq;
      mask_wr   = vt[i].mwr;
      mask_data = vt[i].mdata;
      irq_ack   = vt[i].ack;
      eoi       = vt[i].eoi;
      tick();
      chk($sformatf("v%0d_req", i),  {7'd0, irq_req}, {7'd0, vt[i].req});
      chk($sformatf("v%0d_busy", i), {7'd0, busy},    {7'd0, vt[i].busy});
      chk($sformatf("v%0d_pend", i), pending,         vt[i].pend);
      chk($sformatf("v%0d_mask", i), mask,            vt[i].msk);
      if (vt[i].req)
        chk($sformatf("v%0d_id", i), {5'd0, irq_id}, {5'd0, vt[i].id});
      if (vt[i].busy)
        chk($sformatf("v%0d_act", i), {5'd0, active_id}, {5'd0, vt[i].act});
    end
    irq_in = '0; mask_wr = 1'b0; mask_data = '0; irq_ack = 1'b0; eoi = 1'b0;
    tick();

    // Held level on bit 4 for 20 cycles: exactly one service.
    nsvc     = 0;
    last_ack = 1'b0;
    irq_in   = 8'h10;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (last_ack) begin
        chk("held_busy",    {7'd0, busy}, 8'h01);
        chk("held_active",  {5'd0, active_id}, 8'h04);
        chk("held_pend",    pending, 8'h00);
      end
      irq_ack  = 1'b0;
      eoi      = 1'b0;
      last_ack = 1'b0;
      if (irq_req) begin
        chk("held_id", {5'd0, irq_id}, 8'h04);
        irq_ack  = 1'b1;
        last_ack = 1'b1;
        nsvc++;
      end else if (busy) begin
        eoi = 1'b1;
      end
    end
    irq_in = '0; irq_ack = 1'b0; eoi = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    chk("held_nsvc", 8'(nsvc), 8'h01);
    chk("held_req_end",  {7'd0, irq_req}, 8'h00);
    chk("held_busy_end", {7'd0, busy},    8'h00);
    chk("held_pend_end", pending,         8'h00);

    // Reset asserted mid-REQ with pending = 8'h24 and a non-reset mask.
    irq_in    = 8'h24;
    mask_wr   = 1'b1;
    mask_data = 8'h01;
    tick();
    irq_in  = '0;
    mask_wr = 1'b0;
    tick();
    chk("mid_req",  {7'd0, irq_req}, 8'h01);
    chk("mid_id",   {5'd0, irq_id},  8'h05);
    chk("mid_pend", pending,         8'h24);
    chk("mid_mask", mask,            8'h01);
    #3 rst = 1'b1;
    #1;
    chk("arst_req",    {7'd0, irq_req},   8'h00);
    chk("arst_id",     {5'd0, irq_id},    8'h00);
    chk("arst_busy",   {7'd0, busy},      8'h00);
    chk("arst_active", {5'd0, active_id}, 8'h00);
    chk("arst_pend",   pending,           8'h00);
    chk("arst_mask",   mask,              8'h00);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk($sformatf("post_rst_req%0d", c), {7'd0, irq_req}, 8'h00);
      chk($sformatf("post_rst_pend%0d", c), pending, 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
